sysex_param_parser: RTL and testbench

//  Parses the incoming MIDI byte stream for parameter-write SysEx messages.

---
 rtl/sysex_param_parser.sv | 217 +++++++++++++++++++++
 tb/tb_sysex_param_parser.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysex_param_parser.sv
`default_nettype none
// ============================================================================
// Module  : sysex_param_parser
// Brief   : Extracts bank/address/data parameter writes from MIDI SysEx and
//           presents each one as a stretched data_ready strobe.
// Revision: 1.0  initial release
// ============================================================================
module sysex_param_parser #(
  parameter logic [6:0] MFR_ID   = 7'h7D,
  parameter int         DRDY_LEN = 4,
  parameter int         GAP_LEN  = 4,
  parameter int         MAX_BANK = 4
) (
  input  logic       CLOCK_25,
  input  logic       iRST,
  input  logic [7:0] midi_byte,
  input  logic       midi_valid,
  input  logic [3:0] dev_id,
  output logic       data_ready,
  output logic [2:0] bank_adr,
  output logic [6:0] param_adr,
  output logic [7:0] param_data,
  output logic       msg_active,
  output logic [7:0] err_cnt,
  output logic       overflow
);

  localparam logic [7:0] c_DRDY     = 8'(DRDY_LEN);
  localparam logic [7:0] c_GAP      = 8'(GAP_LEN);
  localparam logic [6:0] c_MAX_BANK = 7'(MAX_BANK);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_MFR  = 4'd1,
    S_DEV  = 4'd2,
    S_CMD  = 4'd3,
    S_BANK = 4'd4,
    S_ADR  = 4'd5,
    S_DHI  = 4'd6,
    S_DLO  = 4'd7,
    S_SKIP = 4'd8
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [6:0] r_grp_bank;
  logic [6:0] r_grp_adr;
  logic       r_grp_dhi;

  logic [7:0] r_pulse_cnt;
  logic [7:0] r_gap_cnt;
  logic       r_pend_vld;
  logic [2:0] r_pend_bank;
  logic [6:0] r_pend_adr;
  logic [7:0] r_pend_data;

  logic [2:0] r_bank_adr;
  logic [6:0] r_param_adr;
  logic [7:0] r_param_data;
  logic [7:0] r_err_cnt;
  logic       r_overflow;

  logic       w_byte_ok;
  logic       w_is_status;
  logic       w_dev_match;
  logic       w_err;
  logic       w_ld_bank;
  logic       w_ld_adr;
  logic       w_ld_dhi;
  logic       w_grp_done;
  logic       w_grp_ok;
  logic       w_err_evt;
  logic       w_out_idle;
  logic [7:0] w_new_data;

  // Real-time bytes (F8..FF) are transparent to the parser.
  assign w_byte_ok   = midi_valid && (midi_byte < 8'hF8);
  assign w_is_status = midi_byte[7];
  assign w_dev_match = (midi_byte == 8'h7F) || (midi_byte == {4'h0, dev_id});

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_ld_bank   = 1'b0;
    w_ld_adr    = 1'b0;
    w_ld_dhi    = 1'b0;
    w_grp_done  = 1'b0;
    if (w_byte_ok) begin
      if (midi_byte == 8'hF0) begin
        w_state_nxt = S_MFR;
        w_err       = (r_state == S_ADR) || (r_state == S_DHI) || (r_state == S_DLO);
      end else begin
        case (r_state)
          S_IDLE: w_state_nxt = S_IDLE;
          S_SKIP: begin
            if (midi_byte == 8'hF7) w_state_nxt = S_IDLE;
          end
          S_MFR, S_DEV, S_CMD: begin
            if (midi_byte == 8'hF7) begin
              w_state_nxt = S_IDLE;
            end else if (w_is_status) begin
              w_state_nxt = S_IDLE;
              w_err       = 1'b1;
            end else if (r_state == S_MFR && midi_byte == {1'b0, MFR_ID}) begin
              w_state_nxt = S_DEV;
            end else if (r_state == S_DEV && w_dev_match) begin
              w_state_nxt = S_CMD;
            end else if (r_state == S_CMD && midi_byte == 8'h01) begin
              w_state_nxt = S_BANK;
            end else begin
              w_state_nxt = S_SKIP;
            end
          end
          S_BANK, S_ADR, S_DHI, S_DLO: begin
            if (w_is_status) begin
              // A clean end of message is only F7 on a group boundary.
              w_state_nxt = S_IDLE;
              w_err       = (midi_byte != 8'hF7) || (r_state != S_BANK);
            end else if (r_state == S_BANK) begin
              w_ld_bank   = 1'b1;
              w_state_nxt = S_ADR;
            end else if (r_state == S_ADR) begin
              w_ld_adr    = 1'b1;
              w_state_nxt = S_DHI;
            end else if (r_state == S_DHI) begin
              w_ld_dhi    = 1'b1;
              w_state_nxt = S_DLO;
            end else begin
              w_grp_done  = 1'b1;
              w_state_nxt = S_BANK;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  assign w_grp_ok   = w_grp_done && (r_grp_bank <= c_MAX_BANK);
  assign w_err_evt  = w_err || (w_grp_done && !w_grp_ok);
  assign w_out_idle = (r_pulse_cnt == 8'd0) && (r_gap_cnt == 8'd0);
  assign w_new_data = {r_grp_dhi, midi_byte[6:0]};

  always_ff @(posedge CLOCK_25) begin
    if (iRST) begin
      r_state      <= S_IDLE;
      r_grp_bank   <= 7'd0;
      r_grp_adr    <= 7'd0;
      r_grp_dhi    <= 1'b0;
      r_pulse_cnt  <= 8'd0;
      r_gap_cnt    <= 8'd0;
      r_pend_vld   <= 1'b0;
      r_pend_bank  <= 3'd0;
      r_pend_adr   <= 7'd0;
      r_pend_data  <= 8'd0;
      r_bank_adr   <= 3'd0;
      r_param_adr  <= 7'd0;
      r_param_data <= 8'd0;
      r_err_cnt    <= 8'd0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_bank) r_grp_bank <= midi_byte[6:0];
      if (w_ld_adr)  r_grp_adr  <= midi_byte[6:0];
      if (w_ld_dhi)  r_grp_dhi  <= midi_byte[0];
      if (w_err_evt && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;

      if (r_pulse_cnt != 8'd0) begin
        r_pulse_cnt <= r_pulse_cnt - 8'd1;
        if (r_pulse_cnt == 8'd1) r_gap_cnt <= c_GAP;
      end else if (r_gap_cnt != 8'd0) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end

      // Outputs only move while the stage is idle, which keeps them stable
      // through the pulse and the decoder's late bank sample.
      if (w_out_idle && r_pend_vld) begin
        r_bank_adr   <= r_pend_bank;
        r_param_adr  <= r_pend_adr;
        r_param_data <= r_pend_data;
        r_pulse_cnt  <= c_DRDY;
        r_pend_vld   <= w_grp_ok;
        if (w_grp_ok) begin
          r_pend_bank <= r_grp_bank[2:0];
          r_pend_adr  <= r_grp_adr;
          r_pend_data <= w_new_data;
        end
      end else if (w_out_idle && w_grp_ok) begin
        r_bank_adr   <= r_grp_bank[2:0];
        r_param_adr  <= r_grp_adr;
        r_param_data <= w_new_data;
        r_pulse_cnt  <= c_DRDY;
      end else if (w_grp_ok) begin
        if (!r_pend_vld) begin
          r_pend_vld  <= 1'b1;
          r_pend_bank <= r_grp_bank[2:0];
          r_pend_adr  <= r_grp_adr;
          r_pend_data <= w_new_data;
        end else begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign data_ready = (r_pulse_cnt != 8'd0);
  assign bank_adr   = r_bank_adr;
  assign param_adr  = r_param_adr;
  assign param_data = r_param_data;
  assign msg_active = (r_state == S_BANK) || (r_state == S_ADR) ||
                      (r_state == S_DHI)  || (r_state == S_DLO);
  assign err_cnt    = r_err_cnt;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sysex_param_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_sysex_param_parser
// Brief   : Directed and randomized SysEx stimulus with a queue scoreboard.
// Revision: 1.0  initial release
// ============================================================================
module tb_sysex_param_parser;

  localparam int DRDY = 4;
  localparam int GAP  = 4;
  localparam int MAXB = 4;
  localparam int MFR  = 'h7D;

  logic       CLOCK_25 = 1'b0;
  logic       iRST = 1'b1;
  logic [7:0] midi_byte = 8'h00;
  logic       midi_valid = 1'b0;
  logic [3:0] dev_id = 4'h0;
  logic       data_ready;
  logic [2:0] bank_adr;
  logic [6:0] param_adr;
  logic [7:0] param_data;
  logic       msg_active;
  logic [7:0] err_cnt;
  logic       overflow;

  sysex_param_parser dut (
    .CLOCK_25  (CLOCK_25),
    .iRST      (iRST),
    .midi_byte (midi_byte),
    .midi_valid(midi_valid),
    .dev_id    (dev_id),
    .data_ready(data_ready),
    .bank_adr  (bank_adr),
    .param_adr (param_adr),
    .param_data(param_data),
    .msg_active(msg_active),
    .err_cnt   (err_cnt),
    .overflow  (overflow)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  int e = 0;
  always @(posedge CLOCK_25) e <= e + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, e);
    end
  endtask

  // ---------------- reference model: message rules + pulse timeline -------
  typedef struct { int bank; int adr; int data; int start; } exp_t;
  exp_t q[$];
  int   last_start = -1000;
  int   m_err = 0;
  int   m_ovf = 0;
  bit   m_in = 0;
  bit   m_foreign = 0;
  int   m_buf[$];

  function automatic void model_clear();
    q.delete();
    m_buf.delete();
    last_start = -1000;
    m_err = 0; m_ovf = 0; m_in = 0; m_foreign = 0;
  endfunction

  function automatic void bump_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic int m_active();
    return (m_in && !m_foreign && m_buf.size() >= 3) ? 1 : 0;
  endfunction

  function automatic bit mid_group();
    return m_in && !m_foreign && m_buf.size() >= 3 && ((m_buf.size() - 3) % 4) != 0;
  endfunction

  // A pulse occupies DRDY high + GAP low cycles; one group may wait in line.
  function automatic void schedule(input int bank, input int adr, input int data, input int ncap);
    int s;
    if (last_start > ncap) begin
      m_ovf = 1;
    end else begin
      s = last_start + DRDY + GAP + 1;
      if (s < ncap) s = ncap;
      q.push_back('{bank, adr, data, s});
      last_start = s;
    end
  endfunction

  function automatic void model_byte(input int b, input int ncap);
    int n;
    if (b >= 'hF8) return;
    if (b == 'hF0) begin
      if (mid_group()) bump_err();
      m_in = 1; m_foreign = 0; m_buf.delete();
      return;
    end
    if (!m_in) return;
    if (m_foreign) begin
      if (b == 'hF7) m_in = 0;
      return;
    end
    if (b >= 'h80) begin
      if (b != 'hF7 || mid_group()) bump_err();
      m_in = 0;
      return;
    end
    n = m_buf.size();
    if ((n == 0 && b != MFR) || (n == 1 && b != 'h7F && b != int'(dev_id)) || (n == 2 && b != 1)) begin
      m_foreign = 1;
      return;
    end
    m_buf.push_back(b);
    n = m_buf.size();
    if (n >= 7 && ((n - 3) % 4) == 0) begin
      if (m_buf[n-4] > MAXB) bump_err();
      else schedule(m_buf[n-4], m_buf[n-3], ((m_buf[n-2] & 1) << 7) | m_buf[n-1], ncap);
    end
  endfunction

  // ---------------- driver ----------------
  task automatic send(input int b);
    midi_byte  = 8'(b);
    midi_valid = 1'b1;
    @(posedge CLOCK_25); #1;
    model_byte(b, e);
    midi_valid = 1'b0;
    midi_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLOCK_25); #1; end
  endtask

  task automatic send_seq(input int s[$], input bit rt);
    foreach (s[i]) begin
      send(s[i]);
      if (rt) send('hF8);
    end
  endtask

  task automatic send_r(input int b);
    send(b);
    if ($urandom_range(0, 9) == 0) send($urandom_range('hF8, 'hFF));
    if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    idle(2);
    iRST = 1'b0;
    model_clear();
  endtask

  task automatic check_zero(input string tag);
    @(negedge CLOCK_25);
    check({tag, "_drdy"}, data_ready, 0);
    check({tag, "_bank"}, bank_adr, 0);
    check({tag, "_adr"},  param_adr, 0);
    check({tag, "_data"}, param_data, 0);
    check({tag, "_act"},  msg_active, 0);
    check({tag, "_err"},  err_cnt, 0);
    check({tag, "_ovf"},  overflow, 0);
    @(posedge CLOCK_25); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit         prev_dr = 0;
  int         hi_len = 0;
  int         n_pulses = 0;
  logic [2:0] h_bank;
  logic [6:0] h_adr;
  logic [7:0] h_data;

  always @(negedge CLOCK_25) begin
    exp_t x;
    if (iRST) begin
      prev_dr = 0;
      hi_len  = 0;
    end else begin
      if (data_ready && !prev_dr) begin
        n_pulses++;
        if (q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          x = q.pop_front();
          check("pulse_start", e, x.start);
          check("bank_adr", bank_adr, x.bank);
          check("param_adr", param_adr, x.adr);
          check("param_data", param_data, x.data);
        end
        h_bank = bank_adr; h_adr = param_adr; h_data = param_data;
        hi_len = 1;
      end else if (data_ready || prev_dr) begin
        if (data_ready) hi_len++;
        else check("pulse_len", hi_len, DRDY);
        check("hold_bank", bank_adr, h_bank);
        check("hold_adr", param_adr, h_adr);
        check("hold_data", param_data, h_data);
      end
      check("err_cnt", err_cnt, m_err);
      check("overflow", overflow, m_ovf);
      check("msg_active", msg_active, m_active());
      prev_dr = data_ready;
    end
  end

  // ---------------- stimulus ----------------
  int t1[$]  = '{'hF0, 'h7D, 'h03, 'h01, 'h02, 'h15, 'h01, 'h05, 'hF7};
  int t2[$]  = '{'hF0, 'h7D, 'h7F, 'h01, 'h03, 'h22, 'h00, 'h44, 'hF7};
  int t2b[$] = '{'hF0, 'h7D, 'h05, 'h01, 'h02, 'h15, 'h01, 'h05, 'hF7};
  int t3[$]  = '{'hF0, 'h7D, 'h03, 'h01, 'h00, 'h01, 'h00, 'h11,
                 'h01, 'h02, 'h01, 'h22, 'h02, 'h03, 'h00, 'h33, 'hF7};
  int t4[$]  = '{'hF0, 'h7D, 'h03, 'h01, 'h06, 'h10, 'h00, 'h20,
                 'h01, 'h11, 'h00, 'h30, 'hF7};
  int t6[$]  = '{'hF0, 'h7D, 'h03, 'h01, 'h02, 'h15, 'h90, 'h01, 'h05, 'hF7};
  int ab[$]  = '{'hF0, 'h7D, 'h03, 'h01, 'h02, 'h90};

  initial begin
    int p0;
    int k;
    int ng;
    int dv;
    dev_id = 4'd3;
    do_reset();
    check_zero("reset");

    p0 = n_pulses; send_seq(t1, 0); idle(12);
    check("t1_pulses", n_pulses - p0, 1);
    check("t1_bank", bank_adr, 2);
    check("t1_adr", param_adr, 'h15);
    check("t1_data", param_data, 'h85);

    dev_id = 4'd9;
    p0 = n_pulses; send_seq(t2, 0); idle(12);
    check("bcast_pulses", n_pulses - p0, 1);
    dev_id = 4'd3;
    p0 = n_pulses; send_seq(t2b, 0); idle(12);
    check("foreign_pulses", n_pulses - p0, 0);
    check("foreign_err", err_cnt, 0);

    p0 = n_pulses; send_seq(t3, 0); idle(30);
    check("b2b_pulses", n_pulses - p0, 2);
    check("b2b_overflow", overflow, 1);

    p0 = n_pulses; send_seq(t4, 0); idle(12);
    check("badbank_pulses", n_pulses - p0, 1);
    check("badbank_err", err_cnt, 1);

    p0 = n_pulses; send_seq(t1, 1); idle(12);
    check("rt_pulses", n_pulses - p0, 1);
    check("rt_data", param_data, 'h85);

    p0 = n_pulses; send_seq(t6, 0); idle(12);
    check("abort_pulses", n_pulses - p0, 0);
    check("abort_err", err_cnt, 2);

    // Reset in the middle of a pulse.
    send_seq(t1, 0);
    k = 0;
    while (!data_ready && k < 20) begin idle(1); k++; end
    check("drdy_before_reset", data_ready, 1);
    do_reset();
    check_zero("midreset");
    p0 = n_pulses; send_seq(t1, 0); idle(12);
    check("after_reset_pulses", n_pulses - p0, 1);
    check("after_reset_data", param_data, 'h85);

    // Randomized messages, including foreign, malformed and bursty traffic.
    for (int m = 0; m < 300; m++) begin
      dev_id = 4'($urandom);
      send_r('hF0);
      send_r(($urandom_range(0, 9) == 0) ? $urandom_range(0, 'h7F) : MFR);
      dv = $urandom_range(0, 9);
      send_r((dv < 7) ? int'(dev_id) : (dv < 9) ? 'h7F : $urandom_range(0, 'h7F));
      send_r(($urandom_range(0, 9) == 0) ? $urandom_range(0, 'h7F) : 1);
      ng = $urandom_range(0, 4);
      for (int g = 0; g < ng; g++) begin
        send_r($urandom_range(0, 6));
        send_r($urandom_range(0, 'h7F));
        if ($urandom_range(0, 19) == 0) send_r(($urandom_range(0, 1) == 1) ? 'hF0 : 'h90);
        send_r($urandom_range(0, 'h7F));
        send_r($urandom_range(0, 'h7F));
      end
      if ($urandom_range(0, 9) != 0) send_r('hF7);
      idle($urandom_range(0, 15));
    end
    idle(40);
    check("rand_queue_empty", q.size(), 0);

    // Error counter saturation.
    dev_id = 4'd3;
    for (int m = 0; m < 260; m++) send_seq(ab, 0);
    idle(4);
    check("err_saturated", err_cnt, 'hFF);
    check("final_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
